// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of one single-port synchronous ROM
// between N requesters. Each requester has a valid/ready request channel
// carrying an address and a valid/ready response channel returning the word.
// Only one ROM read is in flight at a time.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for a request; winner gets req_ready combinationally
//   READ  | rom_en high for exactly one cycle, rom_adr stable
//   RESP  | rsp_valid[gnt] high, rsp_dat = rom_dat, until rsp_ready[gnt]

module rom_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4096,
    parameter int N     = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int IW   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    input  logic [N*AW-1:0]  req_adr,
    output logic [N-1:0]     req_ready,
    output logic [N-1:0]     rsp_valid,
    input  logic [N-1:0]     rsp_ready,
    output logic [WIDTH-1:0] rsp_dat,
    output logic             rom_en,
    output logic [AW-1:0]    rom_adr,
    input  logic [WIDTH-1:0] rom_dat
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gnt;

    logic            any_req;
    logic [IW-1:0]   winner;
    logic [N-1:0]    winner_oh;
    logic [N-1:0]    gnt_oh;
    logic [AW-1:0]   winner_adr;

    // Round-robin pick: scan from ptr+1 upwards (wrapping), first set bit
    // wins. The loop runs from the farthest candidate (ptr itself) down to
    // the nearest (ptr+1) so the last assignment is the highest priority.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] v,
                                              input logic [IW-1:0] p);
        logic [IW-1:0] pick;
        int            idx;
        pick = '0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(p) + k) % N;
            if (v[idx]) pick = IW'(idx);
        end
        return pick;
    endfunction

    // Winner selection and one-hot decodes for the grant and request mux.
    always_comb begin
        any_req    = |req_valid;
        winner     = rr_pick(req_valid, ptr);
        winner_oh  = '0;
        winner_oh[winner] = 1'b1;
        gnt_oh     = '0;
        gnt_oh[gnt] = 1'b1;
        winner_adr = req_adr[int'(winner)*AW +: AW];
    end

    // Request acceptance is combinational so the winner sees ready in the
    // same IDLE cycle it is selected.
    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && any_req) req_ready = winner_oh;
    end

    // The ROM output register holds its word while rom_en is low, so the
    // response data can be a straight pass-through.
    always_comb begin
        rsp_dat = rom_dat;
    end

    // Sequencer: one ROM access at a time, registered rom_en / rsp_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= IW'(N - 1);
            gnt       <= '0;
            rom_adr   <= '0;
            rom_en    <= 1'b0;
            rsp_valid <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        gnt     <= winner;
                        rom_adr <= winner_adr;
                        rom_en  <= 1'b1;
                        state   <= S_READ;
                    end
                end
                S_READ: begin
                    rom_en    <= 1'b0;
                    ptr       <= gnt;
                    rsp_valid <= gnt_oh;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready[gnt]) begin
                        rsp_valid <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    rom_en    <= 1'b0;
                    rsp_valid <= '0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Testbench for rom_arbiter (N=4). A behavioural ROM model feeds rom_dat; a
// transaction-level reference predicts grants, ROM accesses and responses.
module tb_rom_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4096;
    localparam int N     = 4;
    localparam int AW    = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*AW-1:0]  req_adr;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ready;
    logic [WIDTH-1:0] rsp_dat;
    logic             rom_en;
    logic [AW-1:0]    rom_adr;
    logic [WIDTH-1:0] rom_dat = '0;

    rom_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_adr(req_adr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rom_en(rom_en), .rom_adr(rom_adr), .rom_dat(rom_dat)
    );

    always #5 clk = ~clk;

    // ROM contents: word = low byte of adr*33 (so mem[5] = 0xA5)
    function automatic logic [7:0] memw(input logic [AW-1:0] a);
        int unsigned p;
        p = 32'(a) * 33;
        return p[7:0];
    endfunction

    // Behavioural single-port ROM with registered output and shared reset
    always @(posedge clk) begin
        if (rom_en) rom_dat <= rst ? '0 : memw(rom_adr);
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        int            id;
        logic [AW-1:0] adr;
    } txn_t;

    txn_t q[$];
    int   glog[$];
    int   last = N - 1;
    bit   pend = 0;
    int   age = 0;
    bit   started = 0;
    bit   after_rst = 0;
    int   n_done = 0;

    function automatic int rr_ref(input logic [N-1:0] v, input int l);
        for (int k = 1; k <= N; k++)
            if (v[(l + k) % N]) return (l + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Monitor: compares every output each cycle against the model
    always @(negedge clk) begin
        logic [N-1:0] e_rdy, e_vld;
        bit           e_en;
        int           w;
        cyc++;
        if (started) begin
            if (pend) age++;
            w = rr_ref(req_valid, last);
            e_rdy = (!pend && w >= 0) ? oh(w) : '0;
            chk("req_ready", 32'(req_ready), 32'(e_rdy));
            e_en = pend && (age == 1);
            chk("rom_en", 32'(rom_en), 32'(e_en));
            if (e_en) chk("rom_adr", 32'(rom_adr), 32'(q[0].adr));
            if (after_rst) chk("rom_adr_rst", 32'(rom_adr), 32'h0);
            e_vld = (pend && age >= 2) ? oh(q[0].id) : '0;
            chk("rsp_valid", 32'(rsp_valid), 32'(e_vld));
            if (pend && age >= 2) chk("rsp_dat", 32'(rsp_dat), 32'(memw(q[0].adr)));
        end
        after_rst = rst;
        if (rst) begin
            q.delete();
            pend    = 0;
            last    = N - 1;
            started = 1;
        end else if (started) begin
            if (pend && age >= 2) begin
                if (rsp_ready[q[0].id]) begin
                    void'(q.pop_front());
                    pend = 0;
                    n_done++;
                end
            end else if (!pend) begin
                w = rr_ref(req_valid, last);
                if (w >= 0) begin
                    q.push_back('{id: w, adr: req_adr[w*AW +: AW]});
                    glog.push_back(w);
                    last = w;
                    pend = 1;
                    age  = 0;
                end
            end
        end
    end

    // ---------------- stimulus driver ----------------
    logic [N-1:0] sticky = '0;
    bit           rnd_en = 0;

    always begin
        logic [N-1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready & {N{~rst}};
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i] && !sticky[i]) req_valid[i] = 1'b0;
            if (rnd_en && !req_valid[i] && $urandom_range(99) < 40) begin
                req_valid[i] = 1'b1;
                req_adr[i*AW +: AW] = (($urandom_range(7) == 0) ? 12'hFFF : 12'($urandom_range(DEPTH - 1)));
            end
        end
        if (rnd_en) rsp_ready = N'($urandom_range(15));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input int i, input logic [AW-1:0] a);
        req_valid[i] = 1'b1;
        req_adr[i*AW +: AW] = a;
    endtask

    task automatic wait_done(input int target, input int limit);
        int k = 0;
        while (n_done < target && k < limit) begin
            step();
            k++;
        end
        chk("done_count", 32'(n_done), 32'(target));
    endtask

    task automatic wait_grant(input int i, input int limit);
        int k = 0;
        while (k < limit) begin
            @(negedge clk);
            #1;
            if (req_ready[i]) break;
            k++;
        end
        chk("grant_wait", 32'(req_ready[i]), 32'h1);
    endtask

    task automatic wait_rsp(input int i, input int limit);
        int k = 0;
        while (k < limit) begin
            @(negedge clk);
            #1;
            if (rsp_valid[i]) break;
            k++;
        end
        chk("rsp_wait", 32'(rsp_valid[i]), 32'h1);
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while ((pend || req_valid != '0) && k < limit) begin
            step();
            k++;
        end
        chk("drain", 32'({pend, |req_valid}), 32'h0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1;
        req_valid = '0;
        req_adr = '0;
        rsp_ready = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // single access: requester 0, adr 0x005 -> 0xA5
        rsp_ready = '1;
        issue(0, 12'h005);
        wait_done(1, 10);
        chk("first_grant", 32'(glog[0]), 32'h0);
        wait_idle(10);

        // both requesting continuously: grants alternate starting at 0
        pulse_rst();
        base = glog.size();
        sticky = 4'b0011;
        issue(0, 12'h001);
        issue(1, 12'h002);
        wait_done(n_done + 8, 40);
        sticky = '0;
        req_valid = '0;
        wait_idle(10);
        chk("alt_first", 32'(glog[base]), 32'h0);
        for (int k = base + 1; k < glog.size(); k++)
            chk("alt_order", 32'(glog[k]), 32'(1 - glog[k-1]));

        // response backpressure
        rsp_ready = '0;
        step();
        issue(0, 12'h010);
        wait_grant(0, 10);
        step();
        issue(1, 12'h020);
        wait_rsp(0, 10);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_req_ready1", 32'(req_ready[1]), 32'h0);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_rsp_dat", 32'(rsp_dat), 32'(memw(12'h010)));
            chk("bp_rom_en", 32'(rom_en), 32'h0);
        end
        base = glog.size();
        rsp_ready = '1;
        wait_done(n_done + 1, 10);
        wait_grant(1, 5);
        wait_idle(10);
        chk("bp_next_grant", 32'(glog[base]), 32'h1);

        // wrong-port ready while serving requester 1
        rsp_ready = '0;
        step();
        issue(1, 12'h033);
        wait_rsp(1, 10);
        rsp_ready = 4'b0001;
        repeat (3) step();
        chk("wp_hold", 32'(rsp_valid), 32'h2);
        base = n_done;
        rsp_ready = 4'b0010;
        wait_done(base + 1, 5);
        wait_idle(10);

        // reset in READ, then contention: requester 0 must win
        rsp_ready = '1;
        step();
        issue(1, 12'h044);
        wait_grant(1, 10);
        step();
        chk("in_read", 32'(rom_en), 32'h1);
        pulse_rst();
        base = glog.size();
        issue(0, 12'h0AA);
        issue(1, 12'h0BB);
        wait_done(n_done + 2, 20);
        wait_idle(10);
        chk("rst_read_win", 32'(glog[base]), 32'h0);

        // reset in RESP
        rsp_ready = '0;
        step();
        issue(1, 12'h055);
        wait_grant(1, 10);
        step();
        step();
        chk("in_resp", 32'(rsp_valid), 32'h2);
        pulse_rst();
        rsp_ready = '1;
        base = glog.size();
        issue(0, 12'h0CC);
        issue(1, 12'h0DD);
        wait_done(n_done + 2, 20);
        wait_idle(10);
        chk("rst_resp_win", 32'(glog[base]), 32'h0);

        // boundary address on requester 3, then all four contend
        issue(3, 12'hFFF);
        wait_done(n_done + 1, 10);
        wait_idle(10);
        base = glog.size();
        for (int i = 0; i < N; i++) issue(i, 12'(12'h100 + i));
        wait_done(n_done + 4, 30);
        wait_idle(10);
        for (int i = 0; i < N; i++)
            chk("order_after_3", 32'(glog[base + i]), 32'(i));

        // randomized traffic
        rnd_en = 1;
        repeat (3000) step();
        rnd_en = 0;
        rsp_ready = '1;
        wait_idle(300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
